sobel_burst_writer: RTL and testbench



---
 rtl/sobel_burst_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_sobel_burst_writer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_burst_writer.sv
// Edge-detector pixel sink: buffers RGB565 pixels in a FWFT FIFO and hands them to the
// SDRAM write arbiter as fixed-length bursts at linearly increasing frame addresses.
module sobel_burst_writer #(
    parameter int                BURST_LEN  = 32'd256,
    parameter int                FIFO_DEPTH = 32'd1024,
    parameter int                ADDR_W     = 32'd24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}},
    parameter int                FRAME_PIX  = 32'd307200
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          frame_start,
    input  logic                          pix_wr_en,
    input  logic [15:0]                   pix_data,
    output logic                          wr_req,
    input  logic                          wr_ack,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [8:0]                    wr_burst_len,
    input  logic                          wr_data_en,
    output logic [15:0]                   wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(BURST_LEN);

    localparam logic [PTR_W-1:0]  PTR_ZERO   = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [LVL_W-1:0]  LVL_ZERO   = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]  LVL_ONE    = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_FULL   = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0]  LVL_BURST  = LVL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(BASE_ADDR + FRAME_PIX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [15:0]         mem_r [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                pend_r;
    logic                wr_req_r;
    logic [ADDR_W-1:0]   wr_addr_r;
    logic                overflow_r;
    logic                frame_done_r;

    logic                empty_s;
    logic                full_s;
    logic                pop_s;
    logic                last_pop_s;
    logic                flush_s;
    logic                block_s;
    logic                push_s;
    logic                drop_s;
    logic [ADDR_W-1:0]   next_addr_s;
    logic                wrap_s;

    assign empty_s     = (level_r == LVL_ZERO);
    assign full_s      = (level_r == LVL_FULL);
    assign pop_s       = (state_r == ST_XFER) && wr_data_en;
    assign last_pop_s  = pop_s && (cnt_r == CNT_LAST);
    // A flush is immediate outside a burst, otherwise deferred to the burst's final pop.
    assign flush_s     = (frame_start && (state_r != ST_XFER)) ||
                         (last_pop_s && (pend_r || frame_start));
    assign block_s     = frame_start || pend_r;
    assign push_s      = pix_wr_en && !block_s && (!full_s || pop_s);
    assign drop_s      = pix_wr_en && !block_s && full_s && !pop_s;
    assign next_addr_s = wr_addr_r + ADDR_STEP;
    assign wrap_s      = (next_addr_s == FRAME_END);

    assign wr_req       = wr_req_r;
    assign wr_addr      = wr_addr_r;
    assign wr_burst_len = 9'(BURST_LEN);
    assign wr_data      = empty_s ? 16'h0000 : mem_r[rd_ptr_r];
    assign fifo_level   = level_r;
    assign overflow     = overflow_r;
    assign frame_done   = frame_done_r;

    // Next-state logic for the request/transfer handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_s = ST_IDLE;
                end else if (level_r >= LVL_BURST) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (frame_start) begin
                    state_s = ST_IDLE;
                end else if (wr_ack) begin
                    state_s = ST_XFER;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (last_pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_XFER;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register with registered request output.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r  <= ST_IDLE;
            wr_req_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            wr_req_r <= (state_s == ST_REQ);
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= pix_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else if (flush_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                level_r <= level_r + LVL_ONE;
            end else if (pop_s && !push_s) begin
                level_r <= level_r - LVL_ONE;
            end
        end
    end

    // Burst pop counter and deferred frame_start flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_r  <= CNT_ZERO;
            pend_r <= 1'b0;
        end else if (state_r != ST_XFER) begin
            cnt_r  <= CNT_ZERO;
            pend_r <= 1'b0;
        end else begin
            if (pop_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
            pend_r <= last_pop_s ? 1'b0 : (pend_r | frame_start);
        end
    end

    // Frame address, sticky overflow and end-of-frame pulse.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_addr_r    <= BASE_ADDR;
            overflow_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= last_pop_s && wrap_s;
            if (flush_s) begin
                wr_addr_r <= BASE_ADDR;
            end else if (last_pop_s) begin
                wr_addr_r <= wrap_s ? BASE_ADDR : next_addr_s;
            end
            if (flush_s) begin
                overflow_r <= 1'b0;
            end else if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    sobel_burst_writer_chk u_chk (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pop       (pop_s),
        .empty     (empty_s)
    );

endmodule

// Protocol checks for the arbiter side of the burst writer.
module sobel_burst_writer_chk (
    input logic sys_clk,
    input logic sys_rst_n,
    input logic pop,
    input logic empty
);

    // The arbiter must never pop an empty FIFO.
    pop_not_empty_a: assert property (@(posedge sys_clk) disable iff (!sys_rst_n) !(pop && empty));

endmodule

// File: tb/tb_sobel_burst_writer.sv
// Bench for sobel_burst_writer: directed vector table, a reset-in-burst sequence and
// randomized traffic checked against a queue-based model of the FIFO and frame addressing.
module tb_sobel_burst_writer;

    localparam int          BL    = 16;
    localparam int          D     = 64;
    localparam int          FP    = 48;
    localparam logic [23:0] BASE  = 24'h000100;
    localparam logic [23:0] A1    = BASE + 24'd16;
    localparam logic [23:0] A2    = BASE + 24'd32;
    localparam logic [23:0] FEND  = BASE + 24'd48;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        pix_wr_en = 1'b0;
    logic [15:0] pix_data = 16'h0000;
    logic        wr_ack = 1'b0;
    logic        wr_data_en = 1'b0;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [8:0]  wr_burst_len;
    logic [15:0] wr_data;
    logic [6:0]  fifo_level;
    logic        overflow;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    sobel_burst_writer #(
        .BURST_LEN  (BL),
        .FIFO_DEPTH (D),
        .ADDR_W     (24),
        .BASE_ADDR  (BASE),
        .FRAME_PIX  (FP)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .frame_start  (frame_start),
        .pix_wr_en    (pix_wr_en),
        .pix_data     (pix_data),
        .wr_req       (wr_req),
        .wr_ack       (wr_ack),
        .wr_addr      (wr_addr),
        .wr_burst_len (wr_burst_len),
        .wr_data_en   (wr_data_en),
        .wr_data      (wr_data),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .frame_done   (frame_done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic        fs;
        logic        pen;
        logic        ack;
        logic        pop;
        int          reps;
        int          lvl;
        logic        req;
        logic [23:0] addr;
        logic        ovf;
        logic        done;
        logic        sync;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs();
        frame_start = 1'b0;
        pix_wr_en   = 1'b0;
        wr_ack      = 1'b0;
        wr_data_en  = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        sys_rst_n = 1'b0;
        tick();
        tick();
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic add(input logic fs, input logic pen, input logic ack, input logic pop,
                       input int reps, input int lvl, input logic req, input logic [23:0] addr,
                       input logic ovf, input logic done, input logic sync);
        vec_t v;
        v.fs = fs; v.pen = pen; v.ack = ack; v.pop = pop; v.reps = reps; v.lvl = lvl;
        v.req = req; v.addr = addr; v.ovf = ovf; v.done = done; v.sync = sync;
        tbl.push_back(v);
    endtask

    task automatic wait_req(input string name, input int max_cyc);
        int n;
        n = 0;
        while (!wr_req && n < max_cyc) begin
            tick();
            n++;
        end
        chk(name, 32'(wr_req), 32'd1);
    endtask

    // Queue model of FIFO, address sequencing and overflow, with the bench acting as arbiter.
    task automatic run_model(input string tag, input int n_cyc, input int push_pct, input int push_limit,
                             input int dly_lo, input int dly_hi, input int pop_pct,
                             output int bursts, output int done_seen);
        logic [15:0] q[$];
        logic        ovf_m;
        logic        done_m;
        logic [23:0] addr_m;
        int          arb, dly, left, pushes, wait_cnt;
        ovf_m = 1'b0; done_m = 1'b0; addr_m = BASE;
        arb = 0; dly = 0; left = 0; pushes = 0; wait_cnt = 0; bursts = 0; done_seen = 0;
        for (int c = 0; c < n_cyc; c++) begin
            pix_wr_en  = (pushes < push_limit) && ($urandom_range(0, 99) < push_pct);
            pix_data   = 16'($urandom);
            wr_ack     = 1'b0;
            wr_data_en = 1'b0;
            chk({tag, " req_legal"}, 32'(wr_req && (arb == 2 || q.size() < BL)), 32'd0);
            if (arb == 0 && wr_req) begin
                arb = 1;
                dly = $urandom_range(dly_lo, dly_hi);
            end
            if (arb == 1) begin
                if (dly == 0) begin
                    wr_ack = 1'b1;
                    chk({tag, " burst_addr"}, 32'(wr_addr), 32'(addr_m));
                    arb = 2;
                    left = BL;
                    bursts++;
                end else begin
                    dly--;
                end
            end else if (arb == 2) begin
                wr_data_en = ($urandom_range(0, 99) < pop_pct);
                if (wr_data_en) begin
                    if (q.size() > 0) begin
                        chk({tag, " pop_data"}, 32'(wr_data), 32'(q[0]));
                        void'(q.pop_front());
                    end else begin
                        chk({tag, " pop_nonempty"}, 32'd0, 32'd1);
                    end
                    left--;
                    if (left == 0) begin
                        addr_m = addr_m + 24'(BL);
                        if (addr_m == FEND) begin
                            addr_m = BASE;
                            done_m = 1'b1;
                        end
                        arb = 0;
                    end
                end
            end
            if (pix_wr_en) begin
                pushes++;
                if (q.size() < D) q.push_back(pix_data);
                else ovf_m = 1'b1;
            end
            tick();
            chk({tag, " level"}, 32'(fifo_level), 32'(q.size()));
            chk({tag, " overflow"}, 32'(overflow), 32'(ovf_m));
            chk({tag, " frame_done"}, 32'(frame_done), 32'(done_m));
            if (frame_done) done_seen++;
            done_m = 1'b0;
            wait_cnt = (arb == 0 && !wr_req && q.size() >= BL) ? wait_cnt + 1 : 0;
            chk({tag, " req_latency"}, 32'(wait_cnt <= 1), 32'd1);
        end
        clear_inputs();
    endtask

    initial begin
        int push_cnt;
        int pop_cnt;
        int bursts;
        int dones;

        apply_reset();
        chk("rst wr_req", 32'(wr_req), 32'd0);
        chk("rst wr_addr", 32'(wr_addr), 32'(BASE));
        chk("rst level", 32'(fifo_level), 32'd0);
        chk("rst wr_data", 32'(wr_data), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst frame_done", 32'(frame_done), 32'd0);
        chk("burst_len", 32'(wr_burst_len), 32'd16);

        //   fs    pen   ack   pop  reps lvl req   addr  ovf   done  sync
        add(1'b0, 1'b1, 1'b0, 1'b0, 15, 15, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0,  1, 16, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 16, 1'b1, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  2, 16, 1'b1, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 16, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 15,  1, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1,  1,  0, 1'b0, A1,   1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  1,  0, 1'b0, A1,   1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 64, 64, 1'b1, A1,   1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0,  3, 64, 1'b1, A1,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 64, 1'b0, A1,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16, 48, 1'b0, A2,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 48, 1'b1, A2,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 48, 1'b0, A2,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16, 32, 1'b0, BASE, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 32, 1'b1, BASE, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 32, 1'b0, BASE, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16, 16, 1'b0, A1,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  1, 16, 1'b1, A1,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 16, 1'b0, A1,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 16,  0, 1'b0, A2,   1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0,  2,  0, 1'b0, A2,   1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0,  1,  0, 1'b0, BASE, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 20, 20, 1'b1, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0,  1,  0, 1'b0, BASE, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0,  3,  0, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 16, 16, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0,  4, 20, 1'b1, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0,  1, 20, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1,  5, 15, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b1,  1, 14, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1,  9,  5, 1'b0, BASE, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1,  1,  0, 1'b0, BASE, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0,  2,  0, 1'b0, BASE, 1'b0, 1'b0, 1'b0);

        push_cnt = 0;
        pop_cnt  = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                frame_start = tbl[i].fs;
                pix_wr_en   = tbl[i].pen;
                pix_data    = 16'(push_cnt);
                wr_ack      = tbl[i].ack;
                wr_data_en  = tbl[i].pop;
                if (tbl[i].pop) begin
                    chk($sformatf("row%0d data", i), 32'(wr_data), 32'(pop_cnt));
                    pop_cnt++;
                end
                tick();
                if (tbl[i].pen) push_cnt++;
            end
            clear_inputs();
            chk($sformatf("row%0d level", i), 32'(fifo_level), 32'(tbl[i].lvl));
            chk($sformatf("row%0d wr_req", i), 32'(wr_req), 32'(tbl[i].req));
            chk($sformatf("row%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
            chk($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("row%0d frame_done", i), 32'(frame_done), 32'(tbl[i].done));
            if (tbl[i].sync) pop_cnt = push_cnt;
        end

        // Asynchronous reset in the middle of the second burst.
        pix_wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pix_data = 16'(i + 1);
            tick();
        end
        pix_wr_en = 1'b0;
        wait_req("rstseq req1", 4);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        wr_data_en = 1'b1;
        repeat (16) tick();
        wr_data_en = 1'b0;
        chk("rstseq addr1", 32'(wr_addr), 32'(A1));
        wait_req("rstseq req2", 4);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        wr_data_en = 1'b1;
        repeat (5) tick();
        #3;
        sys_rst_n = 1'b0;
        #1;
        chk("async wr_req", 32'(wr_req), 32'd0);
        chk("async wr_addr", 32'(wr_addr), 32'(BASE));
        chk("async level", 32'(fifo_level), 32'd0);
        chk("async wr_data", 32'(wr_data), 32'd0);
        chk("async overflow", 32'(overflow), 32'd0);
        chk("async frame_done", 32'(frame_done), 32'd0);
        wr_data_en = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick();

        apply_reset();
        run_model("rndA", 3000, 60, 1000000, 0, 4, 80, bursts, dones);
        apply_reset();
        run_model("rndB", 1500, 95, 1000000, 3, 12, 50, bursts, dones);
        apply_reset();
        run_model("frame", 200, 100, FP, 5, 5, 100, bursts, dones);
        chk("frame bursts", 32'(bursts), 32'd3);
        chk("frame done_pulses", 32'(dones), 32'd1);
        chk("frame end_addr", 32'(wr_addr), 32'(BASE));
        chk("frame end_level", 32'(fifo_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
